svc_pix_fb: RTL and testbench

Frame buffer writer. Accepts an RGB pixel stream in raster order, tracks x/y internally, and writes each pixel to a linear frame buffer as a single-beat AXI write (AW/W/B). It is the write-side counterpart of the frame-buffer-to-pixel-stream reader and shares its address layout: pixel index times bytes-per-beat, from address 0.

---
 rtl/svc_pix_fb.sv | 109 ++++++++++
 tb/tb_svc_pix_fb.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/svc_pix_fb.sv
// svc_pix_fb: raster pixel stream to single-beat AXI writes into a linear frame buffer; define SVC_PIX_FB_SOF_EN to add s_pix_sof resync
module svc_pix_fb #(
   parameter int H_WIDTH           = 12,
   parameter int V_WIDTH           = 12,
   parameter int COLOR_WIDTH       = 4,
   parameter int AXI_ADDR_WIDTH    = 16,
   parameter int AXI_DATA_WIDTH    = 16,
   parameter int AXI_ID_WIDTH      = 4,
   parameter int OUTSTANDING_WIDTH = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        s_pix_valid,
   input  logic [COLOR_WIDTH-1:0]      s_pix_red,
   input  logic [COLOR_WIDTH-1:0]      s_pix_grn,
   input  logic [COLOR_WIDTH-1:0]      s_pix_blu,
`ifdef SVC_PIX_FB_SOF_EN
   input  logic                        s_pix_sof,
`endif
   output logic                        s_pix_ready,
   input  logic [H_WIDTH-1:0]          h_visible,
   input  logic [V_WIDTH-1:0]          v_visible,
   output logic                        m_axi_awvalid,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]                  m_axi_awlen,
   output logic [2:0]                  m_axi_awsize,
   output logic [1:0]                  m_axi_awburst,
   input  logic                        m_axi_awready,
   output logic                        m_axi_wvalid,
   output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                        m_axi_wlast,
   input  logic                        m_axi_wready,
   input  logic                        m_axi_bvalid,
   input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
   input  logic [1:0]                  m_axi_bresp,
   output logic                        m_axi_bready,
   output logic                        idle,
   output logic                        err
);
   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam int SIZE = $clog2(STRB_W);
   localparam logic [AXI_ADDR_WIDTH-1:0] BEAT = AXI_ADDR_WIDTH'(STRB_W);
   localparam logic [OUTSTANDING_WIDTH:0] MAX_OUT = {1'b1, {OUTSTANDING_WIDTH{1'b0}}};
   logic [H_WIDTH-1:0] x, cur_x, nxt_x;
   logic [V_WIDTH-1:0] y, cur_y, nxt_y;
   logic [AXI_ADDR_WIDTH-1:0] addr, cur_addr, nxt_addr;
   logic [OUTSTANDING_WIDTH:0] outstanding, out_nxt;
   logic aw_free, w_free, accept, sof, x_more, y_more;
   logic unused_bid;
`ifdef SVC_PIX_FB_SOF_EN
   assign sof = s_pix_sof;
`else
   assign sof = 1'b0;
`endif
   assign unused_bid = ^m_axi_bid;
   assign m_axi_awid = '0;
   assign m_axi_awlen = 8'd0;
   assign m_axi_awsize = 3'(SIZE);
   assign m_axi_awburst = 2'b01;
   assign m_axi_wstrb = '1;
   assign m_axi_wlast = 1'b1;
   assign m_axi_bready = 1'b1;
   assign aw_free = !m_axi_awvalid || m_axi_awready;
   assign w_free = !m_axi_wvalid || m_axi_wready;
   assign s_pix_ready = aw_free && w_free && (outstanding < MAX_OUT);
   assign accept = s_pix_valid && s_pix_ready;
   assign idle = !m_axi_awvalid && !m_axi_wvalid && (outstanding == '0);
   // a start-of-frame pixel is treated as (0,0) at address 0 before advancing
   always_comb begin
      cur_x = sof ? '0 : x;
      cur_y = sof ? '0 : y;
      cur_addr = sof ? '0 : addr;
      x_more = cur_x < h_visible - H_WIDTH'(1);
      y_more = cur_y < v_visible - V_WIDTH'(1);
      nxt_x = x_more ? cur_x + H_WIDTH'(1) : '0;
      nxt_y = x_more ? cur_y : (y_more ? cur_y + V_WIDTH'(1) : '0);
      nxt_addr = (!x_more && !y_more) ? '0 : cur_addr + BEAT;
      out_nxt = (accept == m_axi_bvalid) ? outstanding :
                accept ? outstanding + 1'b1 :
                (outstanding == '0) ? outstanding : outstanding - 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         x <= '0;
         y <= '0;
         addr <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid <= 1'b0;
         m_axi_awaddr <= '0;
         m_axi_wdata <= '0;
         outstanding <= '0;
         err <= 1'b0;
      end else begin
         if (accept) begin
            x <= nxt_x;
            y <= nxt_y;
            addr <= nxt_addr;
            m_axi_awaddr <= cur_addr;
            m_axi_wdata <= AXI_DATA_WIDTH'({s_pix_red, s_pix_grn, s_pix_blu});
         end
         m_axi_awvalid <= accept || (m_axi_awvalid && !m_axi_awready);
         m_axi_wvalid <= accept || (m_axi_wvalid && !m_axi_wready);
         outstanding <= out_nxt;
         err <= err || (m_axi_bvalid && m_axi_bresp != 2'b00);
      end
   end
endmodule

// File: tb/tb_svc_pix_fb.sv
// tb_svc_pix_fb: randomized bench for svc_pix_fb against a pixel-index frame model
module tb_svc_pix_fb;
   logic clk = 1'b0;
   logic rst;
   logic s_pix_valid, s_pix_ready, s_pix_sof;
   logic [3:0] s_pix_red, s_pix_grn, s_pix_blu;
   logic [11:0] h_visible, v_visible;
   logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
   logic [3:0] m_axi_awid, m_axi_bid;
   logic [15:0] m_axi_awaddr, m_axi_wdata;
   logic [7:0] m_axi_awlen;
   logic [2:0] m_axi_awsize;
   logic [1:0] m_axi_awburst, m_axi_wstrb, m_axi_bresp;
   logic m_axi_bvalid, m_axi_bready, idle, err;
   int checks = 0;
   int errors = 0;
   int unsigned aw_q[$];
   int unsigned w_q[$];
   int unsigned idx, out_m, acc_cnt, a0, hv, vv;
   bit err_m;
`ifdef SVC_PIX_FB_SOF_EN
   localparam bit SOF = 1'b1;
`else
   localparam bit SOF = 1'b0;
`endif
   always #5 clk = ~clk;
   svc_pix_fb dut (
      .clk(clk), .rst(rst),
      .s_pix_valid(s_pix_valid), .s_pix_red(s_pix_red), .s_pix_grn(s_pix_grn), .s_pix_blu(s_pix_blu),
`ifdef SVC_PIX_FB_SOF_EN
      .s_pix_sof(s_pix_sof),
`endif
      .s_pix_ready(s_pix_ready), .h_visible(h_visible), .v_visible(v_visible),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
      .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
      .m_axi_awready(m_axi_awready), .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata),
      .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
      .m_axi_bready(m_axi_bready), .idle(idle), .err(err)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic bit pct(input int p);
      return $urandom_range(99) < p;
   endfunction
   // one clock: check registered outputs, drive inputs, check ready, update the model
   task automatic cycle(input int pv, input int par, input int pwr, input int pb, input int perr, input int psof);
      bit acc, bhs, ready_e;
      check("awvalid", m_axi_awvalid, aw_q.size() != 0);
      check("wvalid", m_axi_wvalid, w_q.size() != 0);
      check("idle", idle, aw_q.size() == 0 && w_q.size() == 0 && out_m == 0);
      check("err", err, err_m);
      if (aw_q.size() != 0) check("awaddr", m_axi_awaddr, aw_q[0]);
      if (w_q.size() != 0) check("wdata", m_axi_wdata, w_q[0]);
      s_pix_valid = pct(pv);
      s_pix_red = 4'($urandom);
      s_pix_grn = 4'($urandom);
      s_pix_blu = 4'($urandom);
      s_pix_sof = pct(psof);
      m_axi_awready = pct(par);
      m_axi_wready = pct(pwr);
      m_axi_bvalid = pct(pb);
      m_axi_bresp = pct(perr) ? 2'b10 : 2'b00;
      m_axi_bid = 4'($urandom);
      #1;
      ready_e = (aw_q.size() == 0 || m_axi_awready) && (w_q.size() == 0 || m_axi_wready) && out_m < 8;
      check("pix_ready", s_pix_ready, ready_e);
      acc = s_pix_valid && s_pix_ready;
      bhs = m_axi_bvalid;
      if (m_axi_awvalid && m_axi_awready && aw_q.size() != 0) void'(aw_q.pop_front());
      if (m_axi_wvalid && m_axi_wready && w_q.size() != 0) void'(w_q.pop_front());
      if (acc) begin
         if (SOF && s_pix_sof) idx = 0;
         aw_q.push_back((idx * 2) & 32'hffff);
         w_q.push_back({s_pix_red, s_pix_grn, s_pix_blu});
         idx = (idx + 1) % (hv * vv);
         acc_cnt++;
      end
      if (acc && !bhs) out_m++;
      else if (!acc && bhs && out_m > 0) out_m--;
      if (bhs && m_axi_bresp != 2'b00) err_m = 1'b1;
      @(negedge clk);
   endtask
   task automatic do_reset(input int h, input int v);
      rst = 1'b1;
      s_pix_valid = 1'b0;
      m_axi_bvalid = 1'b0;
      m_axi_awready = 1'b1;
      m_axi_wready = 1'b1;
      hv = h;
      vv = v;
      h_visible = 12'(h);
      v_visible = 12'(v);
      @(negedge clk);
      rst = 1'b0;
      aw_q.delete();
      w_q.delete();
      idx = 0;
      out_m = 0;
      err_m = 1'b0;
   endtask
   initial begin
      {s_pix_valid, s_pix_sof, m_axi_awready, m_axi_wready, m_axi_bvalid} = '0;
      {s_pix_red, s_pix_grn, s_pix_blu, m_axi_bresp, m_axi_bid} = '0;
      acc_cnt = 0;
      @(negedge clk);
      do_reset(4, 2);
      check("rst_awvalid", m_axi_awvalid, 0);
      check("rst_wvalid", m_axi_wvalid, 0);
      check("rst_awaddr", m_axi_awaddr, 0);
      check("rst_wdata", m_axi_wdata, 0);
      check("rst_err", err, 0);
      check("rst_idle", idle, 1);
      check("awsize", m_axi_awsize, 1);
      check("awlen", m_axi_awlen, 0);
      check("awburst", m_axi_awburst, 1);
      check("awid", m_axi_awid, 0);
      check("wstrb", m_axi_wstrb, 3);
      check("wlast", m_axi_wlast, 1);
      check("bready", m_axi_bready, 1);
      a0 = acc_cnt;
      repeat (9) cycle(100, 100, 100, 100, 0, 0);
      check("rate_9", acc_cnt - a0, 9);
      repeat (3) cycle(0, 100, 100, 100, 0, 0);
      a0 = acc_cnt;
      repeat (5) cycle(100, 0, 100, 100, 0, 0);
      check("aw_stall_acc", acc_cnt - a0, 1);
      repeat (3) cycle(0, 100, 100, 100, 0, 0);
      a0 = acc_cnt;
      repeat (12) cycle(100, 100, 100, 0, 0, 0);
      check("out_limit", acc_cnt - a0, 8);
      check("out_full_ready", s_pix_ready, 0);
      cycle(100, 100, 100, 100, 0, 0);
      repeat (4) cycle(100, 100, 100, 0, 0, 0);
      check("one_more", acc_cnt - a0, 9);
      repeat (12) cycle(0, 100, 100, 100, 0, 0);
      cycle(0, 100, 100, 100, 100, 0);
      repeat (5) cycle(50, 100, 100, 100, 0, 0);
      check("err_sticky", err, 1);
      repeat (3) cycle(0, 100, 100, 100, 0, 0);
      repeat (3) cycle(100, 100, 100, 0, 0, 0);
      check("busy_3", idle, 0);
      do_reset(4, 2);
      repeat (2) cycle(0, 100, 100, 100, 0, 0);
      check("stale_idle", idle, 1);
      check("err_cleared", err, 0);
      cycle(100, 100, 100, 0, 0, 0);
      check("post_rst_addr", m_axi_awaddr, 0);
      repeat (3) cycle(0, 100, 100, 100, 0, 0);
      if (SOF) begin
         do_reset(4, 2);
         repeat (2) cycle(100, 100, 100, 100, 0, 0);
         cycle(100, 100, 100, 100, 0, 100);
         check("sof_addr", m_axi_awaddr, 0);
         cycle(100, 100, 100, 100, 0, 0);
         check("sof_next", m_axi_awaddr, 2);
         repeat (3) cycle(0, 100, 100, 100, 0, 0);
      end
      do_reset(3, 3);
      repeat (2000) cycle(70, 70, 70, 40, 5, SOF ? 3 : 0);
      repeat (30) cycle(0, 100, 100, 100, 0, 0);
      check("final_idle", idle, 1);
      check("final_q", aw_q.size() + w_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
